// File: rtl/usb_rx_data_checker.sv
// USB receive data-packet checker: validates the PID, checks CRC16 and payload
// length, and forwards the payload downstream with the two CRC bytes stripped.
module usb_rx_data_checker #(
  parameter int unsigned MAX_PAYLOAD = 1023,
  parameter int unsigned LEN_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_lp_sop,
  input  logic             rx_lp_eop,
  input  logic             rx_lp_valid,
  output logic             rx_lp_ready,
  input  logic [7:0]       rx_lp_data,
  output logic             rx_lt_sop,
  output logic             rx_lt_eop,
  output logic             rx_lt_valid,
  input  logic             rx_lt_ready,
  output logic [7:0]       rx_lt_data,
  output logic             rx_lt_err,
  output logic             rx_lt_abort,
  output logic             rx_pid_en,
  output logic [3:0]       rx_pid,
  output logic             pid_err,
  output logic             crc16_err,
  output logic             len_err,
  output logic [LEN_W-1:0] pkt_len
);

  localparam logic [15:0]      CRC_INIT  = 16'hFFFF;
  localparam logic [15:0]      CRC_RESID = 16'h800D;
  localparam logic [15:0]      CRC_POLY  = 16'h8005;
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_PAYLOAD + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP} state_e;

  state_e           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [1:0][7:0]  hold_q, hold_d;
  logic [1:0]       hold_cnt_q, hold_cnt_d;
  logic             sent_q, sent_d;
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic             out_err_q, out_err_d;
  logic             abort_q, abort_d;
  logic             pid_en_q, pid_en_d;
  logic [3:0]       pid_q, pid_d;
  logic             pid_err_q, pid_err_d;
  logic             crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;

  logic             accept;
  logic             out_free;
  logic [15:0]      crc_next;
  logic [LEN_W-1:0] pay_inc;
  logic             pid_ok;
  logic             pid_is_data;
  logic             crc_bad;
  logic             len_bad;

  // Serial CRC16 (x^16+x^15+x^2+1), data bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  assign out_free    = ~out_valid_q | rx_lt_ready;
  assign rx_lp_ready = (state_q != S_DATA) | (hold_cnt_q != 2'd2) | out_free;
  assign accept      = rx_lp_valid & rx_lp_ready;
  assign crc_next    = crc16_byte(crc_q, rx_lp_data);
  assign pay_inc     = (pay_cnt_q == LEN_SAT) ? pay_cnt_q : pay_cnt_q + LEN_W'(1);
  assign pid_ok      = (rx_lp_data[3:0] == ~rx_lp_data[7:4]);
  assign pid_is_data = (rx_lp_data[1:0] == 2'b11);
  assign crc_bad     = (crc_next != CRC_RESID);
  assign len_bad     = (hold_cnt_q == 2'd2) && (pay_inc > LEN_MAX);

  // Next-state: PID decode, hold-buffer shifting, end-of-packet checks.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    sent_d      = sent_q;
    pay_cnt_d   = pay_cnt_q;
    out_valid_d = out_valid_q & ~rx_lt_ready;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q & out_valid_d;
    out_eop_d   = out_eop_q & out_valid_d;
    out_err_d   = out_err_q & out_valid_d;
    abort_d     = 1'b0;
    pid_en_d    = 1'b0;
    pid_d       = pid_q;
    pid_err_d   = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    pkt_len_d   = pkt_len_q;

    if (accept) begin
      if (rx_lp_sop) begin
        // A sop always restarts; the output beat is only ours to drop if this packet forwarded it.
        if ((state_q == S_DATA) && (sent_q || (hold_cnt_q != 2'd0))) begin
          abort_d = 1'b1;
        end
        if ((state_q == S_DATA) && sent_q) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          out_err_d   = 1'b0;
        end
        hold_cnt_d = 2'd0;
        crc_d      = CRC_INIT;
        sent_d     = 1'b0;
        pay_cnt_d  = '0;
        if (!pid_ok) begin
          pid_err_d = 1'b1;
          state_d   = rx_lp_eop ? S_IDLE : S_DROP;
        end else begin
          pid_en_d = 1'b1;
          pid_d    = rx_lp_data[3:0];
          if (pid_is_data) begin
            if (rx_lp_eop) begin
              len_err_d = 1'b1;
              pkt_len_d = '0;
              state_d   = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = rx_lp_eop ? S_IDLE : S_DROP;
          end
        end
      end else begin
        case (state_q)
          S_DATA: begin
            crc_d = crc_next;
            if (hold_cnt_q == 2'd2) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_q[0];
              out_sop_d   = ~sent_q;
              out_eop_d   = rx_lp_eop;
              out_err_d   = 1'b0;
              sent_d      = 1'b1;
              pay_cnt_d   = pay_inc;
              hold_d[0]   = hold_q[1];
              hold_d[1]   = rx_lp_data;
            end else begin
              hold_d[hold_cnt_q[0]] = rx_lp_data;
              hold_cnt_d            = hold_cnt_q + 2'd1;
            end
            if (rx_lp_eop) begin
              state_d    = S_IDLE;
              hold_cnt_d = 2'd0;
              if (hold_cnt_q == 2'd0) begin
                len_err_d = 1'b1;
                pkt_len_d = '0;
              end else begin
                crc_err_d = crc_bad;
                len_err_d = len_bad;
                pkt_len_d = (hold_cnt_q == 2'd2) ? pay_inc : '0;
                if (hold_cnt_q == 2'd2) begin
                  out_err_d = crc_bad | len_bad;
                end
              end
            end
          end
          S_DROP: begin
            if (rx_lp_eop) begin
              state_d = S_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      crc_q       <= CRC_INIT;
      hold_q      <= '0;
      hold_cnt_q  <= 2'd0;
      sent_q      <= 1'b0;
      pay_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      pid_en_q    <= 1'b0;
      pid_q       <= 4'h0;
      pid_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      pkt_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      sent_q      <= sent_d;
      pay_cnt_q   <= pay_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      abort_q     <= abort_d;
      pid_en_q    <= pid_en_d;
      pid_q       <= pid_d;
      pid_err_q   <= pid_err_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      pkt_len_q   <= pkt_len_d;
    end
  end

  assign rx_lt_valid = out_valid_q;
  assign rx_lt_data  = out_data_q;
  assign rx_lt_sop   = out_sop_q;
  assign rx_lt_eop   = out_eop_q;
  assign rx_lt_err   = out_err_q;
  assign rx_lt_abort = abort_q;
  assign rx_pid_en   = pid_en_q;
  assign rx_pid      = pid_q;
  assign pid_err     = pid_err_q;
  assign crc16_err   = crc_err_q;
  assign len_err     = len_err_q;
  assign pkt_len     = pkt_len_q;

endmodule

// File: tb/tb_usb_rx_data_checker.sv
// Scoreboard bench for usb_rx_data_checker: expected beats and PIDs are queued
// by the stimulus, a negedge monitor pops and compares them as the DUT emits.
module tb_usb_rx_data_checker;

  localparam int unsigned MAXP = 16;
  localparam int unsigned LW   = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_lp_sop, rx_lp_eop, rx_lp_valid, rx_lp_ready;
  logic [7:0]    rx_lp_data;
  logic          rx_lt_sop, rx_lt_eop, rx_lt_valid, rx_lt_ready;
  logic [7:0]    rx_lt_data;
  logic          rx_lt_err, rx_lt_abort, rx_pid_en, pid_err, crc16_err, len_err;
  logic [3:0]    rx_pid;
  logic [LW-1:0] pkt_len;

  int checks = 0, failures = 0;
  int n_pid_err = 0, n_crc = 0, n_len = 0, n_abort = 0, n_stall = 0;
  int b_pid_err, b_crc, b_len, b_abort, b_stall;
  logic [10:0] exp_q[$];
  logic [3:0]  pid_q[$];
  logic [7:0]  pay[0:63];
  logic        tog_mode = 1'b0, lt_ready_set = 1'b1, watch_ready = 1'b0;
  logic [3:0]  pat = 4'b1001;

  usb_rx_data_checker #(.MAX_PAYLOAD(MAXP), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_lp_sop(rx_lp_sop), .rx_lp_eop(rx_lp_eop), .rx_lp_valid(rx_lp_valid),
    .rx_lp_ready(rx_lp_ready), .rx_lp_data(rx_lp_data),
    .rx_lt_sop(rx_lt_sop), .rx_lt_eop(rx_lt_eop), .rx_lt_valid(rx_lt_valid),
    .rx_lt_ready(rx_lt_ready), .rx_lt_data(rx_lt_data), .rx_lt_err(rx_lt_err),
    .rx_lt_abort(rx_lt_abort), .rx_pid_en(rx_pid_en), .rx_pid(rx_pid),
    .pid_err(pid_err), .crc16_err(crc16_err), .len_err(len_err), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference CRC-16/USB in reflected form; returns the transmitted (inverted) value.
  function automatic logic [15:0] crc16_usb(input int n);
    logic [15:0] r;
    logic [7:0]  b;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = pay[i];
      for (int j = 0; j < 8; j++) begin
        if (r[0] ^ b[j]) r = (r >> 1) ^ 16'hA001;
        else             r = r >> 1;
      end
    end
    return ~r;
  endfunction

  initial begin
    int k = 0;
    rx_lt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) begin
        rx_lt_ready = pat[k];
        k = (k + 1) % 4;
      end else begin
        rx_lt_ready = lt_ready_set;
      end
    end
  end

  // Monitor: beats, PIDs, pulse counts, stall behaviour.
  initial begin
    logic [10:0] cur, prev_val, e;
    logic        prev_stall;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      cur = {rx_lt_sop, rx_lt_eop, rx_lt_err, rx_lt_data};
      if (prev_stall && rx_lt_valid) chk("hold_stable", int'(cur), int'(prev_val));
      prev_stall = rx_lt_valid && !rx_lt_ready;
      prev_val   = cur;
      if (rx_lt_valid && rx_lt_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", int'(cur), 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", int'(cur), int'(e));
        end
      end
      if (rx_pid_en) begin
        if (pid_q.size() == 0) chk("unexpected_pid", int'(rx_pid), 16);
        else chk("pid", int'(rx_pid), int'(pid_q.pop_front()));
      end
      if (pid_err)     n_pid_err++;
      if (crc16_err)   n_crc++;
      if (len_err)     n_len++;
      if (rx_lt_abort) n_abort++;
      if (watch_ready && !rx_lp_ready) begin
        n_stall++;
        chk("lp_ready_stall", int'(rx_lt_valid && !rx_lt_ready), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    rx_lp_valid = 1'b1; rx_lp_data = d; rx_lp_sop = s; rx_lp_eop = e;
    while (!got) begin
      @(negedge clk);
      got = rx_lp_ready;
      @(posedge clk);
      #1;
      n++;
      if (!got && n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    rx_lp_valid = 1'b0; rx_lp_sop = 1'b0; rx_lp_eop = 1'b0;
  endtask

  task automatic run_pkt(input logic [7:0] pid, input int n, input int flip, input logic exp_err);
    logic [15:0] crc;
    logic [7:0]  b;
    crc = crc16_usb(n);
    pid_q.push_back(pid[3:0]);
    for (int i = 0; i < n; i++) begin
      b = pay[i] ^ ((i == flip) ? 8'h04 : 8'h00);
      exp_q.push_back({i == 0, i == n - 1, (i == n - 1) && exp_err, b});
    end
    send(pid, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) send(pay[i] ^ ((i == flip) ? 8'h04 : 8'h00), 1'b0, 1'b0);
    send(crc[7:0], 1'b0, 1'b0);
    send(crc[15:8], 1'b0, 1'b1);
  endtask

  task automatic snap();
    b_pid_err = n_pid_err; b_crc = n_crc; b_len = n_len; b_abort = n_abort; b_stall = n_stall;
  endtask

  task automatic drain(input string tag, input int exp_len, input int d_crc, input int d_len);
    repeat (25) @(posedge clk);
    #1;
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    chk({tag, "_pid_q_empty"}, pid_q.size(), 0);
    chk({tag, "_pkt_len"}, int'(pkt_len), exp_len);
    chk({tag, "_crc_err_pulses"}, n_crc - b_crc, d_crc);
    chk({tag, "_len_err_pulses"}, n_len - b_len, d_len);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_lp_valid = 1'b0; rx_lp_sop = 1'b0; rx_lp_eop = 1'b0; rx_lp_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lp_ready", int'(rx_lp_ready), 1);
    chk("rst_lt_valid", int'(rx_lt_valid), 0);
    chk("rst_pkt_len", int'(pkt_len), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-length DATA0.
    snap();
    run_pkt(8'hC3, 0, -1, 1'b0);
    drain("zlp", 0, 0, 0);

    // DATA1 with 8 good bytes, then with a corrupted byte.
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    snap();
    run_pkt(8'h4B, 8, -1, 1'b0);
    drain("good8", 8, 0, 0);
    snap();
    run_pkt(8'h4B, 8, 2, 1'b1);
    drain("bad8", 8, 1, 0);

    // Downstream backpressure pattern 1-0-0-1.
    snap();
    tog_mode = 1'b1; watch_ready = 1'b1;
    run_pkt(8'h4B, 8, -1, 1'b0);
    drain("bp8", 8, 0, 0);
    tog_mode = 1'b0; watch_ready = 1'b0;
    chk("bp_stall_seen", int'(n_stall > b_stall), 1);

    // Oversize payload: length saturates at MAXP+1; exactly MAXP is legal.
    for (int i = 0; i < 20; i++) pay[i] = 8'(i * 7 + 3);
    snap();
    run_pkt(8'hC3, 20, -1, 1'b1);
    drain("over20", int'(MAXP) + 1, 0, 1);
    snap();
    run_pkt(8'h4B, 16, -1, 1'b0);
    drain("max16", 16, 0, 0);

    // Too short: PID plus one byte.
    snap();
    pid_q.push_back(4'h3);
    send(8'hC3, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    drain("short", 0, 0, 1);

    // IN token is dropped; 0x5A (NAK) passes the nibble check, 0x5B does not.
    snap();
    pid_q.push_back(4'h9);
    send(8'h69, 1'b1, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1);
    pid_q.push_back(4'hA);
    send(8'h5A, 1'b1, 1'b1);
    send(8'h5B, 1'b1, 1'b1);
    drain("token", 0, 0, 0);
    chk("token_pid_err_pulses", n_pid_err - b_pid_err, 1);
    chk("token_lp_ready", int'(rx_lp_ready), 1);

    // New sop mid-packet aborts the in-flight DATA0.
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h10 + i);
    snap();
    pid_q.push_back(4'h3);
    exp_q.push_back({1'b1, 1'b0, 1'b0, pay[0]});
    exp_q.push_back({1'b0, 1'b0, 1'b0, pay[1]});
    exp_q.push_back({1'b0, 1'b0, 1'b0, pay[2]});
    send(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(pay[i], 1'b0, 1'b0);
    run_pkt(8'hC3, 0, -1, 1'b0);
    drain("abort", 0, 0, 0);
    chk("abort_pulses", n_abort - b_abort, 1);

    // Reset while a stalled beat is on the output.
    snap();
    lt_ready_set = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    pid_q.push_back(4'hB);
    send(8'h4B, 1'b1, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    chk("pre_rst_valid", int'(rx_lt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lt_valid", int'(rx_lt_valid), 0);
    chk("mid_rst_lt_data", int'({rx_lt_sop, rx_lt_data}), 0);
    chk("mid_rst_pid", int'(rx_pid), 0);
    chk("mid_rst_lp_ready", int'(rx_lp_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lt_ready_set = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("post_rst_no_abort", n_abort - b_abort, 0);
    snap();
    run_pkt(8'hC3, 0, -1, 1'b0);
    drain("post_rst_zlp", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
